// File: rtl/neosd_cmd_rx.sv
// SD command-line response receiver for the neosd controller.
// Armed after a command's end bit; waits for a start bit (bounded by an NCR
// timeout), shifts in a 48-bit or 136-bit response, checks CRC7 and the end
// bit, and presents index/payload/status to the register file.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | not armed; ticks ignored; results held for software
// S_WAIT_START | armed, counting SD ticks until cmd line goes low
// S_RECV       | shifting response bits, bitcnt = index of next bit
// S_DONE       | one-clk completion, done_o high, results already valid

module neosd_cmd_rx #(
    parameter int unsigned TIMEOUT_TICKS = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         sd_tick_i,
    input  logic         cmd_i,
    input  logic         start_i,
    input  logic         long_i,
    input  logic         skip_crc_i,
    input  logic         abort_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [5:0]   index_o,
    output logic [127:0] resp_o,
    output logic         crc_err_o,
    output logic         end_err_o,
    output logic         timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_START,
        S_RECV,
        S_DONE
    } state_t;

    localparam logic [7:0] TMO      = 8'(TIMEOUT_TICKS);
    localparam logic [7:0] LAST_LNG = 8'd134;
    localparam logic [7:0] LAST_SHT = 8'd46;

    state_t       state, state_nx;
    logic [7:0]   bitcnt;
    logic [7:0]   tcnt;
    logic [7:0]   tcnt_inc;
    logic [6:0]   crc;
    logic [126:0] sreg;     // only frame bits 127..1 are ever presented
    logic         long_q;
    logic         skip_q;

    // Serial CRC7, polynomial x^7 + x^3 + 1
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic d);
        logic fb;
        fb = c[6] ^ d;
        return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    assign tcnt_inc = tcnt + 8'd1;
    assign busy_o   = (state == S_WAIT_START) || (state == S_RECV);
    assign done_o   = (state == S_DONE);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; abort overrides everything
    always_comb begin
        state_nx = state;
        if (abort_i) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) state_nx = S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (sd_tick_i) begin
                        if (!cmd_i)               state_nx = S_RECV;
                        else if (tcnt_inc == TMO) state_nx = S_DONE;
                    end
                end
                S_RECV: begin
                    if (sd_tick_i && (bitcnt == 8'd0)) state_nx = S_DONE;
                end
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Datapath: counters, shift register, CRC and result registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bitcnt    <= '0;
            tcnt      <= '0;
            crc       <= '0;
            sreg      <= '0;
            long_q    <= 1'b0;
            skip_q    <= 1'b0;
            index_o   <= '0;
            resp_o    <= '0;
            crc_err_o <= 1'b0;
            end_err_o <= 1'b0;
            timeout_o <= 1'b0;
        end else if (!abort_i) begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        index_o   <= '0;
                        resp_o    <= '0;
                        crc_err_o <= 1'b0;
                        end_err_o <= 1'b0;
                        timeout_o <= 1'b0;
                        tcnt      <= '0;
                        crc       <= '0;
                        long_q    <= long_i;
                        skip_q    <= skip_crc_i;
                    end
                end
                S_WAIT_START: begin
                    if (sd_tick_i) begin
                        if (!cmd_i) begin
                            // start bit is 0 and the LFSR is 0, so CRC stays 0
                            bitcnt <= long_q ? LAST_LNG : LAST_SHT;
                        end else begin
                            tcnt <= tcnt_inc;
                            if (tcnt_inc == TMO) timeout_o <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (sd_tick_i) begin
                        sreg   <= {sreg[125:0], cmd_i};
                        bitcnt <= bitcnt - 8'd1;
                        // long frames exclude the 8-bit header from the CRC
                        if (long_q && (bitcnt == 8'd127))
                            crc <= crc7_step(7'd0, cmd_i);
                        else if ((bitcnt >= 8'd8) && (bitcnt <= 8'd127))
                            crc <= crc7_step(crc, cmd_i);
                        if (bitcnt == 8'd0) begin
                            end_err_o <= ~cmd_i;
                            crc_err_o <= !skip_q && (sreg[6:0] != crc);
                            if (long_q) begin
                                index_o <= '0;
                                resp_o  <= {sreg[126:0], 1'b0};
                            end else begin
                                index_o <= sreg[44:39];
                                resp_o  <= {96'd0, sreg[38:7]};
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neosd_cmd_rx.sv
// Directed bench for neosd_cmd_rx: R7/R3/R2 frames, CRC and end-bit errors,
// NCR timeout, abort and asynchronous reset.

module tb_neosd_cmd_rx;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         sd_tick_i;
    logic         cmd_i;
    logic         start_i;
    logic         long_i;
    logic         skip_crc_i;
    logic         abort_i;
    logic         busy_o;
    logic         done_o;
    logic [5:0]   index_o;
    logic [127:0] resp_o;
    logic         crc_err_o;
    logic         end_err_o;
    logic         timeout_o;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int base;
    logic tick_done, tick_busy, after_done;

    logic [119:0] cid;
    logic [6:0]   r2_crc;
    logic [135:0] r2_frame;
    logic [127:0] r2_resp;

    neosd_cmd_rx #(.TIMEOUT_TICKS(64)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sd_tick_i  (sd_tick_i),
        .cmd_i      (cmd_i),
        .start_i    (start_i),
        .long_i     (long_i),
        .skip_crc_i (skip_crc_i),
        .abort_i    (abort_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .index_o    (index_o),
        .resp_o     (resp_o),
        .crc_err_o  (crc_err_o),
        .end_err_o  (end_err_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Count done pulses, sampled mid-cycle
    always @(negedge clk_i) if (done_o === 1'b1) done_cnt++;

    // CRC7 by polynomial long division of M(x)*x^7 by x^7+x^3+1
    function automatic logic [6:0] crc7_div(input logic [119:0] m);
        logic [126:0] v;
        v = {m, 7'b0};
        for (int i = 126; i >= 7; i--)
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        return v[6:0];
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One SD tick carrying bit b; cmd line is flipped between ticks
    task automatic tick(input logic b);
        @(negedge clk_i);
        cmd_i     = b;
        sd_tick_i = 1'b1;
        @(negedge clk_i);
        sd_tick_i = 1'b0;
        cmd_i     = ~b;
        tick_done = done_o;
        @(negedge clk_i);
        tick_busy  = busy_o;
        after_done = done_o;
        @(negedge clk_i);
    endtask

    task automatic send(input logic [135:0] f, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) tick(f[i]);
    endtask

    task automatic arm(input logic lng, input logic skp);
        @(negedge clk_i);
        start_i    = 1'b1;
        long_i     = lng;
        skip_crc_i = skp;
        @(negedge clk_i);
        start_i    = 1'b0;
        long_i     = 1'b0;
        skip_crc_i = 1'b0;
    endtask

    initial begin
        rst_i      = 1'b1;
        sd_tick_i  = 1'b0;
        cmd_i      = 1'b1;
        start_i    = 1'b0;
        long_i     = 1'b0;
        skip_crc_i = 1'b0;
        abort_i    = 1'b0;

        cid      = 120'h0102030405060708090A0B0C0D0E0F;
        r2_crc   = crc7_div(cid);
        r2_frame = {8'h3F, cid, r2_crc, 1'b1};
        r2_resp  = {cid, r2_crc, 1'b0};

        // reset state
        repeat (2) @(negedge clk_i);
        check("rst_busy", 128'(busy_o), 128'd0);
        check("rst_done", 128'(done_o), 128'd0);
        check("rst_resp", resp_o, 128'd0);
        check("rst_flags", 128'({index_o, crc_err_o, end_err_o, timeout_o}), 128'd0);
        rst_i = 1'b0;

        // ticks while idle are ignored
        tick(1'b0);
        tick(1'b0);
        check("idle_ticks_busy", 128'(busy_o), 128'd0);

        // short R7
        arm(1'b0, 1'b0);
        check("r7_busy", 128'(busy_o), 128'd1);
        base = done_cnt;
        repeat (3) tick(1'b1);
        send(136'h08000001AA13, 47, 0);
        check("r7_done_lat", 128'(tick_done), 128'd1);
        check("r7_done_once", 128'(after_done), 128'd0);
        check("r7_busy_after", 128'(tick_busy), 128'd0);
        #1;
        check("r7_done_cnt", 128'(done_cnt - base), 128'd1);
        check("r7_index", 128'(index_o), 128'h08);
        check("r7_resp", resp_o, 128'h1AA);
        check("r7_flags", 128'({crc_err_o, end_err_o, timeout_o}), 128'd0);

        // R7 with corrupted CRC field
        arm(1'b0, 1'b0);
        tick(1'b1);
        send(136'h08000001AA15, 47, 0);
        check("badcrc_err", 128'(crc_err_o), 128'd1);
        check("badcrc_resp", resp_o, 128'h1AA);
        check("badcrc_end", 128'(end_err_o), 128'd0);

        // R3 with CRC check skipped
        arm(1'b0, 1'b1);
        check("arm_clears_crc", 128'(crc_err_o), 128'd0);
        send(136'h3F80FF8000FF, 47, 0);
        check("r3_done", 128'(tick_done), 128'd1);
        check("r3_crc", 128'(crc_err_o), 128'd0);
        check("r3_index", 128'(index_o), 128'h3F);
        check("r3_resp", resp_o, 128'h80FF8000);

        // timeout on the 64th idle tick
        arm(1'b0, 1'b0);
        base = done_cnt;
        repeat (63) tick(1'b1);
        #1;
        check("tmo_not_early", 128'(done_cnt - base), 128'd0);
        check("tmo_busy_63", 128'(busy_o), 128'd1);
        tick(1'b1);
        check("tmo_done", 128'(tick_done), 128'd1);
        check("tmo_flag", 128'(timeout_o), 128'd1);
        check("tmo_resp", resp_o, 128'd0);
        repeat (3) tick(1'b0);
        #1;
        check("tmo_no_more", 128'(done_cnt - base), 128'd1);
        check("tmo_idle", 128'(busy_o), 128'd0);

        // long R2
        arm(1'b1, 1'b0);
        check("r2_clears_tmo", 128'(timeout_o), 128'd0);
        repeat (2) tick(1'b1);
        send(r2_frame, 135, 0);
        check("r2_done", 128'(tick_done), 128'd1);
        check("r2_resp", resp_o, r2_resp);
        check("r2_index", 128'(index_o), 128'd0);
        check("r2_flags", 128'({crc_err_o, end_err_o, timeout_o}), 128'd0);

        // end bit sampled low
        arm(1'b0, 1'b0);
        send(136'h08000001AA12, 47, 0);
        check("enderr_flag", 128'(end_err_o), 128'd1);
        check("enderr_crc", 128'(crc_err_o), 128'd0);

        // abort mid-receive
        arm(1'b0, 1'b0);
        send(136'h08000001AA13, 47, 28);
        check("abort_busy_before", 128'(busy_o), 128'd1);
        base = done_cnt;
        @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        check("abort_busy_drop", 128'(busy_o), 128'd0);
        send(136'h08000001AA13, 27, 0);
        #1;
        check("abort_no_done", 128'(done_cnt - base), 128'd0);

        // asynchronous reset mid-frame, then a clean R7
        arm(1'b0, 1'b0);
        send(136'h08000001AA13, 47, 38);
        check("rst_mid_busy", 128'(busy_o), 128'd1);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_busy", 128'(busy_o), 128'd0);
        check("arst_out", 128'({index_o, done_o, crc_err_o, end_err_o, timeout_o}), 128'd0);
        check("arst_resp", resp_o, 128'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        arm(1'b0, 1'b0);
        tick(1'b1);
        send(136'h08000001AA13, 47, 0);
        check("post_rst_done", 128'(tick_done), 128'd1);
        check("post_rst_index", 128'(index_o), 128'h08);
        check("post_rst_resp", resp_o, 128'h1AA);
        check("post_rst_flags", 128'({crc_err_o, end_err_o, timeout_o}), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/neosd_cmd_rx.md
Name: neosd_cmd_rx

Overview:
- Receives SD command-line responses for the neosd controller; sits directly downstream of the sd_cmd_i pad input.
- Armed by the command engine after a command's end bit. Waits for a start bit, shifts in either a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response, and checks CRC7 and the end bit.
- Presents index, payload and status to the Wishbone register file.

Parameters:
- TIMEOUT_TICKS, 64, max SD-clock ticks to wait for a start bit (NCR) before flagging timeout; legal range 1..255.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- sd_tick_i  in  1  one-clk strobe marking the SD-clock rising edge; cmd_i is sampled only on these cycles
- cmd_i  in  1  synchronised SD CMD line
- start_i  in  1  one-clk pulse that arms the receiver; latches long_i and skip_crc_i
- long_i  in  1  1 = 136-bit R2 response, 0 = 48-bit response
- skip_crc_i  in  1  1 = do not check CRC (R3)
- abort_i  in  1  synchronous return to IDLE; no done pulse
- busy_o  out  1  high in WAIT_START and RECV
- done_o  out  1  one-clk pulse when the response ends or timeout occurs
- index_o  out  6  response bits [45:40] (short responses only)
- resp_o  out  128  payload (see Behaviour)
- crc_err_o  out  1  CRC mismatch
- end_err_o  out  1  end bit sampled as 0
- timeout_o  out  1  no start bit within TIMEOUT_TICKS

Behaviour:
- Reset: state IDLE; every output 0; internal counters and CRC 0.
- State IDLE:
  - start_i=1: clear index_o, resp_o and all error flags; clear the timeout counter; latch long_i and skip_crc_i; go to WAIT_START.
  - start_i while busy is ignored.
- State WAIT_START (per sd_tick_i):
  - cmd_i=0: treat as the start bit (bit N-1, with N = 48 or 136); set bitcnt = N-2; go to RECV.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_TICKS: set timeout_o and go to DONE.
  - cmd_i is never sampled on a tick that coincides with the start_i pulse.
- State RECV (per sd_tick_i):
  - Shift cmd_i into a 136-bit register and decrement bitcnt.
  - Bit 0 sampled: set end_err_o = ~cmd_i and go to DONE.
- CRC7 (polynomial x^7+x^3+1, serial LFSR, initial value 0):
  - Short: covers bits 47..8, including the start and transmission bits. Long: covers bits 127..8 only; the LFSR is cleared before bit 127.
  - Bits 7..1 are compared to the LFSR; mismatch sets crc_err_o unless skip_crc was latched.
- Output mapping:
  - Short: index_o = bits[45:40]; resp_o[31:0] = bits[39:8]; resp_o[127:32] = 0.
  - Long: index_o = 0; resp_o[127:1] = bits[127:1]; resp_o[0] = 0.
- State DONE:
  - Outputs and flags are updated in the same edge as entry. done_o = 1 for exactly that one clk; next state IDLE.
  - Latency: done_o is asserted 1 clk after the tick sampling the end bit.
  - Flags and resp_o hold until the next start_i.
- Transmission bit (bit N-2) is not checked.
- abort_i has priority over start_i and ticks in every state: go to IDLE with no done_o; data and flags are left as-is.
- rst_i mid-operation: immediate return to the reset state.
- Ticks arriving without an armed receiver are ignored. cmd_i toggling between ticks has no effect.

Test Plan:
- Short R7: arm with long=0, skip=0; after 3 idle ticks drive 0x08000001AA13 MSB-first -> done_o once; index_o=0x08, resp_o=0x1AA, crc_err=0, end_err=0, timeout=0; busy_o low the clk after done.
- Short R7 with CRC corrupted: send 0x08000001AA15 (crc7 field 0x0A) -> crc_err_o=1, resp_o=0x1AA. Repeat with skip_crc_i=1 and R3 frame 0x3F80FF8000FF -> crc_err=0, index_o=0x3F, resp_o=0x80FF8000.
- Timeout: arm and hold cmd_i=1 -> done_o and timeout_o exactly on the 64th tick; resp_o=0; no further ticks are consumed.
- Long R2: 136-bit frame with header 0x3F and CID bytes 0x01..0x0F plus a valid CRC7 -> resp_o[127:8]=0x0102..0F, crc_err=0, index_o=0.
- Short frame whose last bit is 0 -> end_err_o=1.
- abort_i mid-RECV -> busy_o drops next clk with no done_o.
- rst_i pulse mid-frame -> all outputs 0 asynchronously; a subsequent normal R7 frame decodes correctly.
